// File: rtl/cpu_start_pkg.sv
// cpu_start_pkg
//   Shared definitions for the 6502 start-up controller: FSM state encoding,
//   default timing parameters (also used by the bench) and a helper that
//   turns a count parameter into its 8-bit terminal-count compare value.
package cpu_start_pkg;

  // 8 MHz clock / (2 * 4) = 1 MHz PHI2
  localparam int unsigned HALF_PERIOD_DEF  = 4;
  // full PHI2 cycles with RESB low; the 6502 needs at least 2
  localparam int unsigned RESET_CYCLES_DEF = 8;

  typedef enum logic [2:0] {
    S_HALTED   = 3'd0,
    S_RELEASE  = 3'd1,
    S_RESET    = 3'd2,
    S_RUN      = 3'd3,
    S_STOPPING = 3'd4,
    S_PAUSED   = 3'd5,
    S_STEP     = 3'd6
  } state_t;

  // Counters run 0..n-1, so the compare value is n-1, truncated to 8 bits.
  function automatic logic [7:0] term_count(input int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/cpu_start_phi2_gen.sv
// cpu_start_phi2_gen
//   PHI2 generator. A phase counter runs 0..HALF_PERIOD-1 and toggles phi2 at
//   the terminal count. Once phi2 has gone high, the high phase always runs to
//   full length, even if enable drops, so the 6502 never sees a runt high
//   phase. While disabled and low, the counter is held at 0, so re-enabling
//   gives the first rising edge exactly HALF_PERIOD clocks later.
// Ports
//   clock      in   system clock
//   reset      in   synchronous, active-high; forces phi2 low immediately
//   enable     in   run request for the generator
//   phi2       out  registered PHI2
//   phi2_rise  out  registered strobe, high in the clock where phi2 goes 0->1
//   phi2_fall  out  registered strobe, high in the clock where phi2 goes 1->0
//   idle_low   out  phi2 will sit low with the counter cleared after this
//                   clock; used by the FSM to finish a stop
module cpu_start_phi2_gen
  import cpu_start_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic phi2,
  output logic phi2_rise,
  output logic phi2_fall,
  output logic idle_low
);

  localparam logic [7:0] PHASE_TC = term_count(HALF_PERIOD);

  logic [7:0] phase_q;
  logic       active;
  logic       at_tc;

  // A high phase keeps the generator running until it has completed.
  assign active = enable | phi2;
  assign at_tc  = (phase_q == PHASE_TC);

  // When disabled and low, the counter clears on the next edge. So "low and
  // disabled" is already as good as "low with counter 0" for stop decisions.
  assign idle_low = ~phi2 & (~enable | (phase_q == 8'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q   <= 8'd0;
      phi2      <= 1'b0;
      phi2_rise <= 1'b0;
      phi2_fall <= 1'b0;
    end else if (active) begin
      if (at_tc) begin
        phase_q   <= 8'd0;
        phi2      <= ~phi2;
        phi2_rise <= ~phi2;
        phi2_fall <= phi2;
      end else begin
        phase_q   <= phase_q + 8'd1;
        phi2_rise <= 1'b0;
        phi2_fall <= 1'b0;
      end
    end else begin
      phase_q   <= 8'd0;
      phi2_rise <= 1'b0;
      phi2_fall <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_start.sv
// cpu_start
//   Drives the 6502 control pins downstream of the SPI boot loader. It
//   generates PHI2, sequences BE and RESB on boot handoff, and supports
//   pause and single-step for debug.
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high
//   run          in   loader level, high = CPU may run
//   bus_release  in   loader level, high = loader has released the bus
//   step         in   one-clock pulse, requests one PHI2 cycle while paused
//   phi2         out  6502 PHI2
//   resb         out  6502 RESB (active low)
//   be           out  6502 BE (high = CPU drives the bus)
//   phi2_rise    out  strobe coincident with phi2 0->1
//   phi2_fall    out  strobe coincident with phi2 1->0
//   running      out  high while in RUN
//
// state      | meaning
// -----------+----------------------------------------------------------
// HALTED     | loader owns bus; be=0, resb=0, PHI2 stopped
// RELEASE    | bus handed to CPU (be=1), PHI2 starts, resb still low
// RESET      | count RESET_CYCLES PHI2 falls with resb low
// RUN        | free-running PHI2, resb=1
// STOPPING   | PHI2 disabled, waiting for it to settle low
// PAUSED     | PHI2 parked low, be/resb held high
// STEP       | exactly one PHI2 cycle, then back to PAUSED
module cpu_start
  import cpu_start_pkg::*;
#(
  parameter int unsigned HALF_PERIOD  = HALF_PERIOD_DEF,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic bus_release,
  input  logic step,
  output logic phi2,
  output logic resb,
  output logic be,
  output logic phi2_rise,
  output logic phi2_fall,
  output logic running
);

  localparam logic [7:0] RST_TC = term_count(RESET_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] fall_cnt_q, fall_cnt_d;
  logic       reclaim_q, reclaim_d;
  logic       be_d, resb_d, running_d;
  logic       gen_en;
  logic       idle_low;

  cpu_start_phi2_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_phi2_gen (
    .clock     (clock),
    .reset     (reset),
    .enable    (gen_en),
    .phi2      (phi2),
    .phi2_rise (phi2_rise),
    .phi2_fall (phi2_fall),
    .idle_low  (idle_low)
  );

  // Generator enable. bus_release is gated in directly so that a reclaim
  // stops a low phase at once instead of waiting for the state change.
  // In STEP, enable drops in the clock of the fall strobe. Otherwise, with
  // HALF_PERIOD=1, the counter would start a second cycle before PAUSED
  // is reached.
  always_comb begin
    gen_en = 1'b0;
    case (state_q)
      S_RELEASE, S_RESET, S_RUN: gen_en = 1'b1;
      S_STEP:                    gen_en = ~phi2_fall;
      default:                   gen_en = 1'b0;
    endcase
    gen_en = gen_en & bus_release;
  end

  always_comb begin
    state_d    = state_q;
    fall_cnt_d = fall_cnt_q;
    reclaim_d  = reclaim_q;
    be_d       = be;
    resb_d     = resb;

    if (state_q != S_HALTED && !bus_release) begin
      // Bus reclaim outranks everything. reclaim_q remembers where STOPPING
      // must end, in case bus_release comes back before phi2 settles.
      be_d       = 1'b0;
      resb_d     = 1'b0;
      fall_cnt_d = 8'd0;
      reclaim_d  = 1'b1;
      state_d    = idle_low ? S_HALTED : S_STOPPING;
    end else begin
      case (state_q)
        S_HALTED: begin
          be_d       = 1'b0;
          resb_d     = 1'b0;
          fall_cnt_d = 8'd0;
          reclaim_d  = 1'b0;
          if (bus_release && run) begin
            be_d    = 1'b1;
            state_d = S_RELEASE;
          end
        end
        S_RELEASE: begin
          be_d    = 1'b1;
          resb_d  = 1'b0;
          state_d = S_RESET;
        end
        S_RESET: begin
          resb_d = 1'b0;
          if (phi2_fall) begin
            if (fall_cnt_q == RST_TC) begin
              fall_cnt_d = 8'd0;
              resb_d     = 1'b1;
              // run dropping during reset still finishes the reset and
              // then parks the CPU.
              state_d    = run ? S_RUN : S_STOPPING;
            end else begin
              fall_cnt_d = fall_cnt_q + 8'd1;
            end
          end
        end
        S_RUN: begin
          if (!run) state_d = S_STOPPING;
        end
        S_STOPPING: begin
          if (idle_low) state_d = reclaim_q ? S_HALTED : S_PAUSED;
        end
        S_PAUSED: begin
          if (run)       state_d = S_RUN;
          else if (step) state_d = S_STEP;
        end
        S_STEP: begin
          if (phi2_fall) state_d = S_PAUSED;
        end
        default: state_d = S_HALTED;
      endcase
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_HALTED;
      fall_cnt_q <= 8'd0;
      reclaim_q  <= 1'b0;
      be         <= 1'b0;
      resb       <= 1'b0;
      running    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fall_cnt_q <= fall_cnt_d;
      reclaim_q  <= reclaim_d;
      be         <= be_d;
      resb       <= resb_d;
      running    <= running_d;
    end
  end

endmodule
